// File: rtl/celula_2de3_comp.sv
// Registered 2-of-3 threshold cell with hysteresis (TH23), one independent cell per lane.
// Inputs pass through an optional synchronizer chain before reaching the state flop.
module celula_2de3_comp #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] z
);

  // Set on two or more ones, clear on all zeros, otherwise keep the current state.
  function automatic logic [WIDTH-1:0] th23_next(
    input logic [WIDTH-1:0] sa_v,
    input logic [WIDTH-1:0] sb_v,
    input logic [WIDTH-1:0] sc_v,
    input logic [WIDTH-1:0] z_v
  );
    logic [WIDTH-1:0] majority;
    logic [WIDTH-1:0] any_one;
    majority  = (sa_v & sb_v) | (sa_v & sc_v) | (sb_v & sc_v);
    any_one   = sa_v | sb_v | sc_v;
    th23_next = majority | (z_v & any_one);
  endfunction

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sc;
  logic [WIDTH-1:0] z_p1;

  // Stage p0: input synchronizer chains (bypassed entirely when SYNC_STAGES is 0)
  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign sa = a;
      assign sb = b;
      assign sc = c;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][WIDTH-1:0] a_sync_p0;
      logic [SYNC_STAGES-1:0][WIDTH-1:0] b_sync_p0;
      logic [SYNC_STAGES-1:0][WIDTH-1:0] c_sync_p0;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_sync_p0 <= '0;
          b_sync_p0 <= '0;
          c_sync_p0 <= '0;
        end else begin
          a_sync_p0[0] <= a;
          b_sync_p0[0] <= b;
          c_sync_p0[0] <= c;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            a_sync_p0[k] <= a_sync_p0[k-1];
            b_sync_p0[k] <= b_sync_p0[k-1];
            c_sync_p0[k] <= c_sync_p0[k-1];
          end
        end
      end

      assign sa = a_sync_p0[SYNC_STAGES-1];
      assign sb = b_sync_p0[SYNC_STAGES-1];
      assign sc = c_sync_p0[SYNC_STAGES-1];
    end
  endgenerate

  // Stage p1: cell state; the output is taken straight from this flop so it cannot glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_p1 <= '0;
    end else begin
      z_p1 <= th23_next(sa, sb, sc, z_p1);
    end
  end

  assign z = z_p1;

endmodule

// File: tb/tb_celula_2de3_comp.sv
// Scoreboard bench: two 4-lane cells (two-stage synchronizer and no synchronizer) driven
// with identical stimulus and compared every cycle against a lane-by-lane counting model.
module tb_celula_2de3_comp;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;
  logic [3:0] z2;
  logic [3:0] z0;

  int checks;
  int failures;

  logic [3:0]  q2[$];
  logic [3:0]  q0[$];
  logic [11:0] pipe2[$];
  logic [3:0]  zexp2;
  logic [3:0]  zexp0;

  celula_2de3_comp #(.WIDTH(4), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .z(z2)
  );

  celula_2de3_comp #(.WIDTH(4), .SYNC_STAGES(0)) dut0 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .z(z0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count the ones per lane; two or more sets, none clears, exactly one keeps the old value.
  function automatic logic [3:0] th_model(input logic [11:0] code, input logic [3:0] zprev);
    logic [3:0] r;
    int n;
    r = zprev;
    for (int i = 0; i < 4; i++) begin
      n = int'(code[i]) + int'(code[4+i]) + int'(code[8+i]);
      if (n >= 2)      r[i] = 1'b1;
      else if (n == 0) r[i] = 1'b0;
      else             r[i] = zprev[i];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe2.delete();
    pipe2.push_back(12'h000);
    pipe2.push_back(12'h000);
    zexp2 = 4'b0000;
    zexp0 = 4'b0000;
  endtask

  // One cycle: drive at the falling edge (optionally asserting reset a little later,
  // between edges) and push what each cell must show after the next rising edge.
  task automatic step(input logic [3:0] av, input logic [3:0] bv, input logic [3:0] cv,
                      input logic r, input bit mid);
    logic [11:0] code;
    @(negedge clk);
    a = av;
    b = bv;
    c = cv;
    if (mid) begin
      #2;
      rst = r;
      #1;
      check("async_rst_z2", z2, 4'b0000);
      check("async_rst_z0", z0, 4'b0000);
    end else begin
      rst = r;
    end
    if (rst) begin
      model_reset();
    end else begin
      pipe2.push_back({cv, bv, av});
      code  = pipe2.pop_front();
      zexp2 = th_model(code, zexp2);
      zexp0 = th_model({cv, bv, av}, zexp0);
    end
    q2.push_back(zexp2);
    q0.push_back(zexp0);
  endtask

  task automatic code_all(input logic [2:0] abc, input int cycles);
    for (int k = 0; k < cycles; k++)
      step({4{abc[2]}}, {4{abc[1]}}, {4{abc[0]}}, 1'b0, 1'b0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q2.size() > 0) check("sb_z_sync2", z2, q2.pop_front());
      if (q0.size() > 0) check("sb_z_sync0", z0, q0.pop_front());
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    a = 4'hF;
    b = 4'hF;
    c = 4'hF;
    model_reset();

    // Reset held with 111, then released into a single-one code
    for (int k = 0; k < 5; k++) step(4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
    code_all(3'b001, 30);
    check("hold_after_reset", z2, 4'b0000);

    // Set/clear sequences
    code_all(3'b000, 10); code_all(3'b001, 10); code_all(3'b000, 10);
    code_all(3'b010, 10); code_all(3'b000, 10);
    code_all(3'b011, 10); code_all(3'b000, 10);
    code_all(3'b101, 10); code_all(3'b000, 10);
    code_all(3'b110, 10); code_all(3'b000, 10);
    code_all(3'b111, 10); code_all(3'b000, 10);

    // Hysteresis
    code_all(3'b011, 10); code_all(3'b001, 10);
    check("hyst_hold_one_001", z2, 4'b1111);
    code_all(3'b100, 10);
    check("hyst_hold_one_100", z2, 4'b1111);
    code_all(3'b000, 10);
    code_all(3'b100, 10);
    check("hyst_hold_zero_100", z2, 4'b0000);
    code_all(3'b110, 10); code_all(3'b010, 10);
    check("hyst_hold_one_010", z2, 4'b1111);

    // Every ordered pair of codes
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        code_all(3'(i), 10);
        code_all(3'(j), 10);
      end

    // Latency: no-sync cell on the first edge, two-stage cell on the third
    code_all(3'b000, 10);
    code_all(3'b011, 1);
    @(posedge clk); #1;
    check("lat_sync0_edge1", z0, 4'b1111);
    check("lat_sync2_edge1", z2, 4'b0000);
    code_all(3'b011, 1);
    code_all(3'b011, 1);
    @(posedge clk); #1;
    check("lat_sync2_edge3", z2, 4'b1111);
    code_all(3'b011, 5);

    // Lanes on different codes: 011, 001 (after 000), 111, 000
    code_all(3'b000, 10);
    for (int k = 0; k < 10; k++) step(4'b0100, 4'b0101, 4'b0111, 1'b0, 1'b0);
    check("multilane_z2", z2, 4'b0101);
    check("multilane_z0", z0, 4'b0101);

    // Reset asserted between edges while z is set
    code_all(3'b111, 6);
    step(4'hF, 4'hF, 4'hF, 1'b1, 1'b1);
    step(4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
    code_all(3'b100, 10);
    check("post_reset_single_one", z2, 4'b0000);

    // Randomized segments with occasional mid-cycle resets
    for (int s = 0; s < 60; s++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      logic [3:0] rc;
      int hold;
      ra = 4'($urandom);
      rb = 4'($urandom);
      rc = 4'($urandom);
      hold = int'($urandom_range(1, 8));
      if ($urandom_range(0, 9) == 0) begin
        step(ra, rb, rc, 1'b1, 1'b1);
        step(ra, rb, rc, 1'b1, 1'b0);
      end
      for (int k = 0; k < hold; k++) step(ra, rb, rc, 1'b0, 1'b0);
    end

    @(posedge clk);
    #3;
    checks++;
    if (q2.size() != 0 || q0.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", q2.size(), q0.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
